// File: rtl/mmu_pkg.sv
// mmu_pkg: shared address-map constants for the 6809 MMU and decoder
package mmu_pkg;
    localparam logic [7:0]  FFXX_PAGE = 8'hFF;
    localparam logic [7:0]  FE_PAGE   = 8'hFE;
    localparam logic [3:0]  UART_NIB  = 4'h0;
    localparam logic [3:0]  CF_NIB    = 4'h2;
    localparam logic [3:0]  RTC_NIB   = 4'h4;
    localparam logic [15:0] PTE_BASE  = 16'hFEC0;
    localparam logic [15:0] USERMODE  = 16'hFEFF;
    localparam int          PTE_VALID = 7;
endpackage

// File: rtl/mmu_pagetable.sv
// mmu_pagetable: eight 8-bit page table entries, written on E fall, read combinationally
module mmu_pagetable (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] pte [8];

    // clear every entry on reset, otherwise store the CPU write on the falling E edge
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) pte[i] <= 8'h00;
        end else if (we) begin
            pte[waddr] <= wdata;
        end
    end

    assign rdata = pte[raddr];
endmodule

// File: rtl/mmu_decode.sv
// mmu_decode: 6809 address decoder, chip selects, page translation and kernel/user mode
module mmu_decode
    import mmu_pkg::*;
(
    input  logic        i_eclk,
    input  logic        i_reset_n,
    input  logic        i_rw,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_data,
    input  logic        i_kmodeset,
    output logic        romcs_n,
    output logic        ramcs_n,
    output logic        uartcs_n,
    output logic        cfcs_n,
    output logic        rtccs_n,
    output logic [5:0]  paddr,
    output logic        pgfault_n,
    output logic        ffxx,
    output logic        kernio,
    output logic        kupper,
    output logic        kernel
);
    logic [7:0] pte;
    logic       pte_we;
    logic       pte_unused;

    assign pte_we = kernel && !i_rw && i_addr[15:3] == PTE_BASE[15:3];

    mmu_pagetable u_pagetable (
        .clk   (i_eclk),
        .rst_n (i_reset_n),
        .we    (pte_we),
        .waddr (i_addr[2:0]),
        .wdata (i_data),
        .raddr (i_addr[15:13]),
        .rdata (pte)
    );

    // vector fetches force kernel mode; touching $FEFF in kernel drops to user mode
    always_ff @(negedge i_eclk or negedge i_reset_n) begin
        if (!i_reset_n) kernel <= 1'b1;
        else if (i_kmodeset) kernel <= 1'b1;
        else if (kernel && i_addr == USERMODE) kernel <= 1'b0;
    end

    assign pte_unused = pte[6];
    assign ffxx      = i_addr[15:8] == FFXX_PAGE;
    assign kernio    = kernel && i_addr[15:8] == FE_PAGE;
    assign kupper    = kernel && i_addr[15];
    assign paddr     = pte[5:0];
    assign pgfault_n = kernel || ffxx || pte[PTE_VALID];
    assign romcs_n   = !(ffxx || (kupper && !kernio));
    assign uartcs_n  = !(kernio && i_addr[7:4] == UART_NIB);
    assign cfcs_n    = !(kernio && i_addr[7:4] == CF_NIB);
    assign rtccs_n   = !(kernio && i_addr[7:4] == RTC_NIB);
    assign ramcs_n   = !(!ffxx && !kupper && pgfault_n);
endmodule

// File: tb/tb_mmu_decode.sv
// tb_mmu_decode: directed self-checking bench for mmu_decode
module tb_mmu_decode;
    logic        i_eclk = 1'b1;
    logic        i_reset_n = 1'b0;
    logic        i_rw = 1'b1;
    logic [15:0] i_addr = 16'h0000;
    logic [7:0]  i_data = 8'h00;
    logic        i_kmodeset = 1'b0;
    logic        romcs_n, ramcs_n, uartcs_n, cfcs_n, rtccs_n;
    logic [5:0]  paddr;
    logic        pgfault_n, ffxx, kernio, kupper, kernel;
    logic [4:0]  cs;
    logic [7:0]  pte_vals [8];
    int          checks = 0;
    int          failures = 0;

    mmu_decode dut (
        .i_eclk     (i_eclk),
        .i_reset_n  (i_reset_n),
        .i_rw       (i_rw),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .i_kmodeset (i_kmodeset),
        .romcs_n    (romcs_n),
        .ramcs_n    (ramcs_n),
        .uartcs_n   (uartcs_n),
        .cfcs_n     (cfcs_n),
        .rtccs_n    (rtccs_n),
        .paddr      (paddr),
        .pgfault_n  (pgfault_n),
        .ffxx       (ffxx),
        .kernio     (kernio),
        .kupper     (kupper),
        .kernel     (kernel)
    );

    always #5 i_eclk = ~i_eclk;

    assign cs = {romcs_n, ramcs_n, uartcs_n, cfcs_n, rtccs_n};

    task automatic step(input logic [15:0] a, input logic rw, input logic [7:0] d, input logic k);
        @(posedge i_eclk);
        i_addr = a;
        i_rw = rw;
        i_data = d;
        i_kmodeset = k;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        pte_vals = '{8'h80, 8'h82, 8'h83, 8'h84, 8'h8C, 8'h8D, 8'h0E, 8'h8F};
        repeat (2) @(posedge i_eclk);
        i_reset_n = 1'b1;
        step(16'h0200, 1'b1, 8'h00, 1'b0);
        chk("rst_kernel", kernel, 1);
        chk("k0200_cs", cs, 5'b10111);
        chk("rst_paddr", paddr, 0);
        step(16'h8000, 1'b1, 8'h00, 1'b0);
        chk("k8000_cs", cs, 5'b01111);
        chk("k8000_kupper", kupper, 1);
        step(16'hFE00, 1'b1, 8'h00, 1'b0);
        chk("kFE00_cs", cs, 5'b11011);
        chk("kFE00_kernio", kernio, 1);
        step(16'hFE20, 1'b1, 8'h00, 1'b0);
        chk("kFE20_cs", cs, 5'b11101);
        step(16'hFE40, 1'b1, 8'h00, 1'b0);
        chk("kFE40_cs", cs, 5'b11110);
        step(16'hFE80, 1'b1, 8'h00, 1'b0);
        chk("kFE80_cs", cs, 5'b11111);
        step(16'hFF00, 1'b1, 8'h00, 1'b0);
        chk("kFF00_cs", cs, 5'b01111);
        chk("kFF00_ffxx", ffxx, 1);
        for (int i = 0; i < 8; i++) step(16'hFEC0 + 16'(i), 1'b0, pte_vals[i], 1'b0);
        step(16'hFEC3, 1'b1, 8'h00, 1'b0);
        chk("kFEC3_cs", cs, 5'b11111);
        step(16'hFEFF, 1'b1, 8'h00, 1'b0);
        chk("kFEFF_still_kernel", kernel, 1);
        step(16'h0000, 1'b1, 8'h00, 1'b0);
        chk("user_kernel", kernel, 0);
        chk("u0000_cs", cs, 5'b10111);
        chk("u0000_kernio", kernio, 0);
        step(16'h8000, 1'b1, 8'h00, 1'b0);
        chk("u8000_cs", cs, 5'b10111);
        chk("u8000_kupper", kupper, 0);
        chk("u8000_paddr", paddr, 6'h0C);
        step(16'hFE00, 1'b1, 8'h00, 1'b0);
        chk("uFE00_cs", cs, 5'b10111);
        chk("uFE00_kernio", kernio, 0);
        step(16'hFF00, 1'b1, 8'h00, 1'b0);
        chk("uFF00_cs", cs, 5'b01111);
        step(16'h1234, 1'b1, 8'h00, 1'b0);
        chk("u1234_pa", {pgfault_n, paddr}, {1'b1, 6'h00});
        step(16'h2222, 1'b1, 8'h00, 1'b0);
        chk("u2222_pa", {pgfault_n, paddr}, {1'b1, 6'h02});
        step(16'h4004, 1'b1, 8'h00, 1'b0);
        chk("u4004_pa", {pgfault_n, paddr}, {1'b1, 6'h03});
        step(16'h6543, 1'b1, 8'h00, 1'b0);
        chk("u6543_pa", {pgfault_n, paddr}, {1'b1, 6'h04});
        step(16'hABCD, 1'b1, 8'h00, 1'b0);
        chk("uABCD_pa", {pgfault_n, paddr}, {1'b1, 6'h0D});
        step(16'hFEED, 1'b1, 8'h00, 1'b0);
        chk("uFEED_pa", {pgfault_n, paddr}, {1'b1, 6'h0F});
        step(16'hDDDD, 1'b1, 8'h00, 1'b0);
        chk("uDDDD_pa", {pgfault_n, paddr}, {1'b0, 6'h0E});
        chk("uDDDD_cs", cs, 5'b11111);
        step(16'hFEC6, 1'b0, 8'h86, 1'b0);
        chk("uFEC6_wr_cs", cs, 5'b10111);
        step(16'hDDDD, 1'b1, 8'h00, 1'b0);
        chk("user_wr_ignored", {pgfault_n, paddr}, {1'b0, 6'h0E});
        step(16'hDDDD, 1'b1, 8'h00, 1'b1);
        step(16'hDDDD, 1'b1, 8'h00, 1'b0);
        chk("kmodeset_kernel", kernel, 1);
        chk("kDDDD_pa", {pgfault_n, paddr}, {1'b1, 6'h0E});
        chk("kDDDD_cs", cs, 5'b01111);
        step(16'hFEFF, 1'b1, 8'h00, 1'b1);
        step(16'h0200, 1'b1, 8'h00, 1'b0);
        chk("kmodeset_wins", kernel, 1);
        step(16'hFEFF, 1'b0, 8'h00, 1'b0);
        step(16'h8000, 1'b1, 8'h00, 1'b0);
        chk("wrFEFF_user", kernel, 0);
        chk("pre_rst_paddr", paddr, 6'h0C);
        i_reset_n = 1'b0;
        #1;
        chk("async_rst_kernel", kernel, 1);
        chk("async_rst_paddr", paddr, 0);
        chk("async_rst_cs", cs, 5'b01111);
        i_addr = 16'h0000;
        #1;
        chk("async_rst_p0", paddr, 0);
        @(posedge i_eclk);
        i_reset_n = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
